// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit port: FSM encoding and status word layout.
package uart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    localparam int STATUS_FULL      = 0;
    localparam int STATUS_BUSY      = 1;
    localparam int STATUS_OVERFLOW  = 2;
    localparam int STATUS_COUNT_LSB = 3;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO is taken
// only when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wrPtr_q;
    logic [DEPTH_LOG2-1:0] rdPtr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  doPush;
    logic                  doPop;

    assign full   = (count_q == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty  = (count_q == '0);
    assign count  = count_q;
    assign dout   = mem_q[rdPtr_q];
    assign doPop  = pop & ~empty;
    assign doPush = push & (~full | doPop);

    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
            if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clock) begin
        if (doPush) mem_q[wrPtr_q] <= din;
    end

endmodule

// File: rtl/uart_tx_port.sv
// Bus-side UART transmitter: edge-qualified CPU writes feed a TX FIFO that is
// drained 8N1 onto tx; status reads are combinational.
module uart_tx_port
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_BIT  = 434,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        uart_status_cs,
    input  logic        uart_data_cs,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        data_out_valid,
    output logic        tx
);

    localparam int BAUD_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCKS_PER_BIT - 1);

    tx_state_e             state_q, state_d;
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [2:0]            bitIdx_q, bitIdx_d;
    logic [7:0]            shift_q, shift_d;
    logic                  tx_q, tx_d;
    logic                  overflow_q, overflow_d;
    logic                  dataWrPrev_q, statWrPrev_q;

    logic                  dataWrite, statusWrite, baudEnd;
    logic                  fifoPop, fifoFull, fifoEmpty;
    logic [7:0]            fifoDout;
    logic [FIFO_DEPTH_LOG2:0] fifoCount;
    logic [31:0]           statusWord;
    logic                  unusedDataBits;

    assign unusedDataBits = ^{data_in[31:8], data_in[1:0]};

    // A held strobe acts only on its first cycle.
    assign dataWrite   = write & uart_data_cs   & ~dataWrPrev_q;
    assign statusWrite = write & uart_status_cs & ~statWrPrev_q;
    assign baudEnd     = (baud_q == BAUD_LAST);

    sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (dataWrite),
        .pop   (fifoPop),
        .din   (data_in[7:0]),
        .dout  (fifoDout),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .count (fifoCount)
    );

    // A drop in the same cycle as a clear wins, so no overflow is ever lost.
    assign overflow_d = (dataWrite & fifoFull & ~fifoPop)
                      | (overflow_q & ~(statusWrite & data_in[STATUS_OVERFLOW]));

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q + 1'b1;
        bitIdx_d = bitIdx_q;
        shift_d  = shift_q;
        fifoPop  = 1'b0;
        case (state_q)
            TX_IDLE: begin
                baud_d = '0;
                if (!fifoEmpty) begin
                    fifoPop = 1'b1;
                    shift_d = fifoDout;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (baudEnd) begin
                    baud_d   = '0;
                    bitIdx_d = '0;
                    state_d  = TX_DATA;
                end
            end
            TX_DATA: begin
                if (baudEnd) begin
                    baud_d   = '0;
                    shift_d  = {1'b0, shift_q[7:1]};
                    bitIdx_d = bitIdx_q + 1'b1;
                    if (bitIdx_q == 3'd7) state_d = TX_STOP;
                end
            end
            TX_STOP: begin
                if (baudEnd) begin
                    baud_d = '0;
                    if (!fifoEmpty) begin
                        fifoPop = 1'b1;
                        shift_d = fifoDout;
                        state_d = TX_START;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase

        // tx follows the state being entered so the pin itself is a flop.
        case (state_d)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= TX_IDLE;
            baud_q       <= '0;
            bitIdx_q     <= '0;
            shift_q      <= '0;
            tx_q         <= 1'b1;
            overflow_q   <= 1'b0;
            dataWrPrev_q <= 1'b0;
            statWrPrev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            bitIdx_q     <= bitIdx_d;
            shift_q      <= shift_d;
            tx_q         <= tx_d;
            overflow_q   <= overflow_d;
            dataWrPrev_q <= write & uart_data_cs;
            statWrPrev_q <= write & uart_status_cs;
        end
    end

    always_comb begin
        statusWord = '0;
        statusWord[STATUS_FULL]     = fifoFull;
        statusWord[STATUS_BUSY]     = (state_q != TX_IDLE) | ~fifoEmpty;
        statusWord[STATUS_OVERFLOW] = overflow_q;
        statusWord[STATUS_COUNT_LSB +: FIFO_DEPTH_LOG2 + 1] = fifoCount;
    end

    assign data_out_valid = read & (uart_status_cs | uart_data_cs);
    assign data_out       = (read & uart_status_cs) ? statusWord : 32'd0;
    assign tx             = tx_q;

endmodule

// File: tb/tb_uart_tx_port.sv
// Self-checking bench for uart_tx_port: a serial monitor decodes tx frames and
// compares them against a queue of bytes the bench expects to be transmitted.
module tb_uart_tx_port;

    localparam int CPB = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        uart_status_cs = 1'b0;
    logic        uart_data_cs = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        data_out_valid;
    logic        tx;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    logic [7:0] expQ[$];
    int frameStarts[$];

    typedef struct {
        string       name;
        logic        rd;
        logic        sCs;
        logic        dCs;
        logic        expValid;
        logic [31:0] expData;
    } readVec_t;

    readVec_t readTable[5];

    uart_tx_port #(
        .CLOCKS_PER_BIT  (CPB),
        .FIFO_DEPTH_LOG2 (4)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .uart_status_cs (uart_status_cs),
        .uart_data_cs   (uart_data_cs),
        .read           (read),
        .write          (write),
        .data_in        (data_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .tx             (tx)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Drives one write strobe for a single edge; called at posedge+1.
    task automatic applyStimulus(input logic isData, input logic [31:0] value,
                                 input bit accept);
        uart_data_cs   = isData;
        uart_status_cs = ~isData;
        data_in        = value;
        write          = 1'b1;
        @(posedge clock);
        #1;
        write          = 1'b0;
        uart_data_cs   = 1'b0;
        uart_status_cs = 1'b0;
        if (isData && accept) expQ.push_back(value[7:0]);
    endtask

    task automatic readStatus(output logic [31:0] word);
        read           = 1'b1;
        uart_status_cs = 1'b1;
        #1;
        word           = data_out;
        read           = 1'b0;
        uart_status_cs = 1'b0;
    endtask

    task automatic waitIdle(input int budget, input string name);
        logic [31:0] w;
        int n;
        n = 0;
        readStatus(w);
        while (w[1] && n < budget) begin
            @(posedge clock);
            #1;
            readStatus(w);
            n++;
        end
        checkOutput({name, " busy cleared"}, {31'd0, w[1]}, 32'd0);
        repeat (3) @(posedge clock);
        #1;
        checkOutput({name, " all bytes sent"}, expQ.size(), 32'd0);
    endtask

    // Serial monitor: samples each bit mid-period and discards frames cut by reset.
    initial begin : monitor
        logic [9:0] frameBits;
        bit aborted;
        forever begin
            @(negedge clock);
            if (!reset && tx === 1'b0) begin
                frameStarts.push_back(cyc);
                frameBits = '0;
                aborted   = 1'b0;
                for (int k = 1; k < 10 * CPB; k++) begin
                    @(negedge clock);
                    if (reset) aborted = 1'b1;
                    if (k % CPB == CPB / 2) frameBits[k / CPB] = tx;
                end
                if (!aborted) begin
                    checkOutput("frame start bit", {31'd0, frameBits[0]}, 32'd0);
                    checkOutput("frame stop bit", {31'd0, frameBits[9]}, 32'd1);
                    if (expQ.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("[TB] FAIL unexpected frame: got 0x%02h, expected no frame",
                                 frameBits[8:1]);
                    end else begin
                        checkOutput("frame data", {24'd0, frameBits[8:1]}, {24'd0, expQ.pop_front()});
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [31:0] w;
        int base;
        int writeCyc;

        readTable[0] = '{"read status",         1'b1, 1'b1, 1'b0, 1'b1, 32'h87};
        readTable[1] = '{"read data reg",       1'b1, 1'b0, 1'b1, 1'b1, 32'h0};
        readTable[2] = '{"status cs no read",   1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        readTable[3] = '{"read no cs",          1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        readTable[4] = '{"data cs no read",     1'b0, 1'b0, 1'b1, 1'b0, 32'h0};

        // Test 1: reset state
        repeat (3) @(posedge clock);
        #1;
        checkOutput("tx during reset", {31'd0, tx}, 32'd1);
        reset = 1'b0;
        @(posedge clock);
        #1;
        read = 1'b1;
        uart_status_cs = 1'b1;
        #1;
        checkOutput("reset status valid", {31'd0, data_out_valid}, 32'd1);
        checkOutput("reset status word", data_out, 32'd0);
        read = 1'b0;
        uart_status_cs = 1'b0;
        checkOutput("reset tx idle", {31'd0, tx}, 32'd1);

        // Test 2: single frame timing and busy window
        @(posedge clock);
        #1;
        base = frameStarts.size();
        applyStimulus(1'b1, 32'h55, 1'b1);
        writeCyc = cyc;
        readStatus(w);
        checkOutput("status after first write", w, 32'h0A);
        repeat (40) @(posedge clock);
        #1;
        readStatus(w);
        checkOutput("busy in last stop cycle", w, 32'h02);
        @(posedge clock);
        #1;
        readStatus(w);
        checkOutput("status after frame", w, 32'h00);
        checkOutput("frame count t2", frameStarts.size() - base, 32'd1);
        checkOutput("start latency t2", frameStarts[base] - writeCyc, 32'd1);
        checkOutput("t2 queue drained", expQ.size(), 32'd0);

        // Test 3: back-to-back frames with no idle gap
        @(posedge clock);
        #1;
        base = frameStarts.size();
        applyStimulus(1'b1, 32'h01, 1'b1);
        writeCyc = cyc;
        @(posedge clock);
        #1;
        applyStimulus(1'b1, 32'h02, 1'b1);
        @(posedge clock);
        #1;
        applyStimulus(1'b1, 32'h03, 1'b1);
        waitIdle(200, "t3");
        checkOutput("frame count t3", frameStarts.size() - base, 32'd3);
        checkOutput("t3 first start", frameStarts[base] - writeCyc, 32'd1);
        checkOutput("t3 gap 1-2", frameStarts[base + 1] - frameStarts[base], 32'd40);
        checkOutput("t3 gap 2-3", frameStarts[base + 2] - frameStarts[base + 1], 32'd40);

        // Test 4: fill, overflow, read decode table, overflow clear
        @(posedge clock);
        #1;
        for (int i = 0; i < 18; i++) begin
            applyStimulus(1'b1, 32'h10 + i, i < 17);
            @(posedge clock);
            #1;
        end
        for (int i = 0; i < 5; i++) begin
            read           = readTable[i].rd;
            uart_status_cs = readTable[i].sCs;
            uart_data_cs   = readTable[i].dCs;
            #1;
            checkOutput({readTable[i].name, " valid"}, {31'd0, data_out_valid},
                        {31'd0, readTable[i].expValid});
            checkOutput({readTable[i].name, " data"}, data_out, readTable[i].expData);
            read           = 1'b0;
            uart_status_cs = 1'b0;
            uart_data_cs   = 1'b0;
        end
        @(posedge clock);
        #1;
        applyStimulus(1'b0, 32'h4, 1'b0);
        readStatus(w);
        checkOutput("status after overflow clear", w, 32'h83);
        waitIdle(17 * 40 + 100, "t4");

        // Test 5: held write strobe pushes once
        @(posedge clock);
        #1;
        base = frameStarts.size();
        uart_data_cs = 1'b1;
        data_in      = 32'hA5;
        write        = 1'b1;
        expQ.push_back(8'hA5);
        @(posedge clock);
        #1;
        readStatus(w);
        checkOutput("held write cycle 1", w, 32'h0A);
        @(posedge clock);
        #1;
        readStatus(w);
        checkOutput("held write cycle 2", w, 32'h02);
        @(posedge clock);
        #1;
        readStatus(w);
        checkOutput("held write cycle 3", w, 32'h02);
        write        = 1'b0;
        uart_data_cs = 1'b0;
        waitIdle(100, "t5");
        checkOutput("frame count t5", frameStarts.size() - base, 32'd1);

        // Test 6: reset mid-DATA aborts the frame and flushes the queued byte
        @(posedge clock);
        #1;
        base = frameStarts.size();
        applyStimulus(1'b1, 32'hC3, 1'b0);
        @(posedge clock);
        #1;
        applyStimulus(1'b1, 32'h3C, 1'b0);
        repeat (8) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("tx after reset edge", {31'd0, tx}, 32'd1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        readStatus(w);
        checkOutput("status after reset", w, 32'h0);
        repeat (60) @(posedge clock);
        #1;
        readStatus(w);
        checkOutput("status long after reset", w, 32'h0);
        checkOutput("no frame after reset", frameStarts.size() - base, 32'd1);
        checkOutput("tx idle after reset", {31'd0, tx}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
